// File: rtl/hazard_ctrl.sv
// Load-use and redirect sequencer for the 5-stage core. It decides each cycle whether PC and IF/ID advance, stall or are squashed.
// Optional perf counters are enabled with `define HAZARD_PERF_EN; without it stall_count/flush_count are tied to 0.
module hazard_ctrl #(
  parameter int FLUSH_CYCLES  = 2,
  parameter int LOAD_EX_STALL = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_wr_addr,
  input  logic             ex_load,
  input  logic [4:0]       mem_wr_addr,
  input  logic             mem_load,
  input  logic             redirect,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
  typedef enum logic [1:0] {ACT_RUN, ACT_STALL, ACT_FLUSH} action_t;

  // Reload values are only used when the matching sequence lasts longer than one cycle.
  localparam logic [2:0] FLUSH_RELOAD = 3'((FLUSH_CYCLES  > 1) ? FLUSH_CYCLES  - 2 : 0);
  localparam logic [2:0] STALL_RELOAD = 3'((LOAD_EX_STALL > 1) ? LOAD_EX_STALL - 2 : 0);

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;
  action_t    act;
  logic       hz_ex, hz_mem;

  assign hz_ex  = ex_load && (ex_wr_addr != 5'd0) &&
                  ((ex_wr_addr == id_rs) || (id_uses_rt && (ex_wr_addr == id_rt)));
  assign hz_mem = mem_load && (mem_wr_addr != 5'd0) &&
                  ((mem_wr_addr == id_rs) || (id_uses_rt && (mem_wr_addr == id_rt)));

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_n = state;
    cnt_n   = cnt;
    act     = ACT_RUN;
    if (redirect) begin
      // A redirect wins in every state: it aborts a stall and restarts a flush.
      act = ACT_FLUSH;
      if (FLUSH_CYCLES == 1) begin
        state_n = RUN;
      end else begin
        state_n = FLUSH;
        cnt_n   = FLUSH_RELOAD;
      end
    end else begin
      unique case (state)
        RUN: begin
          if (hz_ex) begin
            act = ACT_STALL;
            if (LOAD_EX_STALL > 1) begin
              state_n = STALL;
              cnt_n   = STALL_RELOAD;
            end
          end else if (hz_mem) begin
            act = ACT_STALL;
          end
        end
        STALL, FLUSH: begin
          act = (state == STALL) ? ACT_STALL : ACT_FLUSH;
          if (cnt == 3'd0) state_n = RUN;
          else             cnt_n   = cnt - 3'd1;
        end
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      state <= RUN;
      cnt   <= 3'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // While reset is held the front end is frozen and ID/EX is filled with nops.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (!rst_n) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (act == ACT_STALL) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
    end else if (act == ACT_FLUSH) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  assign stall = (state == STALL);

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en && (stall_q != '1))   stall_q <= stall_q + CNT_W'(1);
      if (redirect && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a cycle-count model checked every negedge, plus literal pins on each scenario.
// Counter expectations follow HAZARD_PERF_EN (saturating at CNT_W=2) or stay zero without it.
module tb_hazard_ctrl;

  localparam int FC  = 2;
  localparam int LES = 2;
  localparam int CW  = 2;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    id_rs = '0, id_rt = '0, ex_wr_addr = '0, mem_wr_addr = '0;
  logic          id_uses_rt = 1'b0, ex_load = 1'b0, mem_load = 1'b0, redirect = 1'b0;
  logic          pc_en, ifid_en, ifid_flush, idex_bubble, stall;
  logic [CW-1:0] stall_count, flush_count;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_CYCLES(FC), .LOAD_EX_STALL(LES), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_wr_addr(ex_wr_addr), .ex_load(ex_load),
    .mem_wr_addr(mem_wr_addr), .mem_load(mem_load),
    .redirect(redirect),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .stall(stall), .stall_count(stall_count), .flush_count(flush_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: count how many more forced stall / flush cycles remain, instead of tracking states.
  int stall_left = 0, flush_left = 0, m_stall_cnt = 0, m_flush_cnt = 0;
  bit e_pc, e_ifen, e_fl, e_bub, e_stall;

  function automatic bit reads(input bit ld, input logic [4:0] w);
    return ld && (w != 0) && ((w == id_rs) || (id_uses_rt && (w == id_rt)));
  endfunction

  task automatic expect_act(input bit p, input bit f, input bit b);
    e_pc = p; e_ifen = p; e_fl = f; e_bub = b;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_left = 0; flush_left = 0; m_stall_cnt = 0; m_flush_cnt = 0;
      expect_act(1'b0, 1'b1, 1'b1);
      e_stall = 1'b0;
    end else begin
      e_stall = (stall_left > 0);
      if (redirect) begin
        expect_act(1'b1, 1'b1, 1'b1); flush_left = FC - 1; stall_left = 0;
      end else if (flush_left > 0) begin
        expect_act(1'b1, 1'b1, 1'b1); flush_left--;
      end else if (stall_left > 0) begin
        expect_act(1'b0, 1'b0, 1'b1); stall_left--;
      end else if (reads(ex_load, ex_wr_addr)) begin
        expect_act(1'b0, 1'b0, 1'b1); stall_left = LES - 1;
      end else if (reads(mem_load, mem_wr_addr)) begin
        expect_act(1'b0, 1'b0, 1'b1);
      end else begin
        expect_act(1'b1, 1'b0, 1'b0);
      end
    end
    check("cyc_pc_en",       32'(pc_en),       32'(e_pc));
    check("cyc_ifid_en",     32'(ifid_en),     32'(e_ifen));
    check("cyc_ifid_flush",  32'(ifid_flush),  32'(e_fl));
    check("cyc_idex_bubble", 32'(idex_bubble), 32'(e_bub));
    check("cyc_stall",       32'(stall),       32'(e_stall));
    check("cyc_stall_count", 32'(stall_count), 32'(m_stall_cnt));
    check("cyc_flush_count", 32'(flush_count), 32'(m_flush_cnt));
    if (PERF && rst_n) begin
      if (!e_pc && m_stall_cnt < CMAX) m_stall_cnt++;
      if (redirect && m_flush_cnt < CMAX) m_flush_cnt++;
    end
  end

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input bit urt,
                        input logic [4:0] exw, input bit exl,
                        input logic [4:0] memw, input bit meml, input bit rd);
    id_rs = rs; id_rt = rt; id_uses_rt = urt;
    ex_wr_addr = exw; ex_load = exl; mem_wr_addr = memw; mem_load = meml; redirect = rd;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    next_cyc(); #2;
    check("rst_pc_en", 32'(pc_en), 32'd0);
    check("rst_ifid_flush", 32'(ifid_flush), 32'd1);
    check("rst_idex_bubble", 32'(idex_bubble), 32'd1);
    check("rst_stall", 32'(stall), 32'd0);

    next_cyc(); rst_n = 1'b1; #2;
    check("run_pc_en", 32'(pc_en), 32'd1);

    // lw $t0 in EX, add $t1,$t0,$t2 in ID: two stall cycles
    next_cyc(); set_in(5'd8, 5'd10, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0); #2;
    check("t1_c0_pc_en", 32'(pc_en), 32'd0);
    check("t1_c0_stall", 32'(stall), 32'd0);
    next_cyc(); #2;
    check("t1_c1_pc_en", 32'(pc_en), 32'd0);
    check("t1_c1_stall", 32'(stall), 32'd1);
    next_cyc(); idle(); #2;
    check("t1_done_pc_en", 32'(pc_en), 32'd1);

    // lw $t0 only in MEM: single stall, stays RUN
    next_cyc(); set_in(5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0); #2;
    check("t2_pc_en", 32'(pc_en), 32'd0);
    check("t2_bubble", 32'(idex_bubble), 32'd1);
    next_cyc(); idle(); #2;
    check("t2_after_stall", 32'(stall), 32'd0);
    check("t2_after_pc_en", 32'(pc_en), 32'd1);

    // reg 0 never hazards; rt ignored unless id_uses_rt
    next_cyc(); set_in(5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0); #2;
    check("t3_zero_pc_en", 32'(pc_en), 32'd1);
    next_cyc(); set_in(5'd9, 5'd8, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0); #2;
    check("t3_addi_pc_en", 32'(pc_en), 32'd1);
    next_cyc(); set_in(5'd9, 5'd8, 1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0); #2;
    check("t3_rt_pc_en", 32'(pc_en), 32'd0);
    next_cyc(); idle(); #2;
    check("t3_rt_stall_held", 32'(stall), 32'd1);
    next_cyc();

    // redirect: two flush cycles, then redirect re-armed in the second cycle
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1); #2;
    check("t4_c0_flush", 32'(ifid_flush), 32'd1);
    check("t4_c0_pc_en", 32'(pc_en), 32'd1);
    next_cyc(); redirect = 1'b0; #2;
    check("t4_c1_flush", 32'(ifid_flush), 32'd1);
    next_cyc(); #2;
    check("t4_c2_flush", 32'(ifid_flush), 32'd0);
    next_cyc(); redirect = 1'b1;
    next_cyc(); #2;
    check("t4_rr_c1_flush", 32'(ifid_flush), 32'd1);
    next_cyc(); set_in(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0); #2;
    check("t4_rr_c2_flush_hz_ignored", 32'(ifid_flush), 32'd1);
    check("t4_rr_c2_pc_en", 32'(pc_en), 32'd1);
    next_cyc(); idle(); #2;
    check("t4_rr_done_flush", 32'(ifid_flush), 32'd0);

    // redirect and hz_ex together: flush wins
    next_cyc(); set_in(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1); #2;
    check("t5_both_pc_en", 32'(pc_en), 32'd1);
    check("t5_both_flush", 32'(ifid_flush), 32'd1);
    next_cyc(); idle(); #2;
    check("t5_no_stall_state", 32'(stall), 32'd0);
    check("t5_flush_cont", 32'(ifid_flush), 32'd1);
    // redirect in STALL aborts it
    next_cyc(); set_in(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0);
    next_cyc(); redirect = 1'b1; #2;
    check("t5_abort_flush", 32'(ifid_flush), 32'd1);
    check("t5_abort_stall_reg", 32'(stall), 32'd1);
    next_cyc(); idle(); #2;
    check("t5_abort_after_stall", 32'(stall), 32'd0);
    // reset mid-STALL
    next_cyc(); set_in(5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0);
    next_cyc(); #1;
    check("t5_pre_rst_stall", 32'(stall), 32'd1);
    rst_n = 1'b0; #1;
    check("t5_rst_pc_en", 32'(pc_en), 32'd0);
    check("t5_rst_ifid_en", 32'(ifid_en), 32'd0);
    check("t5_rst_flush", 32'(ifid_flush), 32'd1);
    check("t5_rst_stall", 32'(stall), 32'd0);
    next_cyc(); rst_n = 1'b1; idle(); #2;
    check("t5_release_pc_en", 32'(pc_en), 32'd1);
    check("t5_release_stall", 32'(stall), 32'd0);

    // five 1-cycle MEM stalls: counter saturates at 3 with CNT_W=2
    next_cyc(); set_in(5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    repeat (4) next_cyc();
    next_cyc(); idle(); #2;
    check("t6_stall_count", 32'(stall_count), PERF ? 32'd3 : 32'd0);
    check("t6_flush_count", 32'(flush_count), 32'd0);

    next_cyc(); redirect = 1'b1;
    next_cyc(); idle(); #2;
    check("t6_flush_count_one", 32'(flush_count), PERF ? 32'd1 : 32'd0);

    repeat (3) next_cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
